bias_add_sched_layer5: RTL

// - Sequences layer-5 bias addition after the adder trees.
// - Accumulates N_adder_tree partial-sum lanes over NUM_PASSES input-channel passes.
// - On the last pass, adds the current channel group's bias vector, applies optional ReLU and saturates.
// - Steps through NUM_GROUPS bias groups (group0 = BIAS_layer5_1 q, group1 = BIAS_layer5_2 q) and emits one result vector per group.

---
 rtl/bias_add_sched_layer5_pkg.sv | 37 +++
 rtl/bias_add_sched_layer5_lane_sat.sv | 35 +++
 rtl/bias_add_sched_layer5.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/bias_add_sched_layer5_pkg.sv
// Shared types and output clamping helpers for the layer-5 bias-add scheduler.
package layer5_pkg;

  localparam int BIAS_W  = 18;
  localparam int PSUM_W  = 18;
  localparam int OUT_W   = 18;
  localparam int WIDE_W  = 32;
  localparam int OUT_MAX = 131071;
  localparam int OUT_MIN = -131072;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    EMIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Signed saturation of a wide sum into the 18-bit output range.
  function automatic logic signed [OUT_W-1:0] sat18(input logic signed [WIDE_W-1:0] x);
    if (x > WIDE_W'(OUT_MAX))
      return 18'sh1FFFF;
    else if (x < -WIDE_W'(131072))
      return 18'sh20000;
    else
      return x[OUT_W-1:0];
  endfunction

  function automatic logic signed [OUT_W-1:0] relu18(input logic signed [WIDE_W-1:0] x);
    if (x < 0)
      return '0;
    else if (x > WIDE_W'(OUT_MAX))
      return 18'sh1FFFF;
    else
      return x[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/bias_add_sched_layer5_lane_sat.sv
// One output lane: running accumulation and the final sum+bias with clamp.
module bias_lane_sat
  import layer5_pkg::*;
#(
  parameter int ACC_W   = 24,
  parameter bit RELU_EN = 1'b1
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [PSUM_W-1:0] psum,
  input  logic signed [BIAS_W-1:0] bias,
  output logic signed [ACC_W-1:0]  acc_next,
  output logic signed [OUT_W-1:0]  result
);

  logic signed [ACC_W:0]    sum_w;
  logic signed [WIDE_W-1:0] sum_x;

  assign acc_next = acc + {{(ACC_W-PSUM_W){psum[PSUM_W-1]}}, psum};

  // One guard bit above the accumulator so acc+psum+bias cannot wrap before clamping.
  assign sum_w = {acc[ACC_W-1], acc}
               + {{(ACC_W+1-PSUM_W){psum[PSUM_W-1]}}, psum}
               + {{(ACC_W+1-BIAS_W){bias[BIAS_W-1]}}, bias};

  assign sum_x = {{(WIDE_W-ACC_W-1){sum_w[ACC_W]}}, sum_w};

  generate
    if (RELU_EN) begin : g_relu
      assign result = relu18(sum_x);
    end else begin : g_sat
      assign result = sat18(sum_x);
    end
  endgenerate

endmodule

// File: rtl/bias_add_sched_layer5.sv
// Layer-5 bias scheduler: accumulates psum passes per group, adds the group bias, emits one vector per group.
module bias_add_sched_layer5
  import layer5_pkg::*;
#(
  parameter int N_adder_tree = 8,
  parameter int NUM_GROUPS   = 2,
  parameter int NUM_PASSES   = 4,
  parameter int ACC_W        = 24,
  parameter bit RELU_EN      = 1'b1,
  localparam int GRP_W       = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1,
  localparam int PASS_W      = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [NUM_GROUPS*N_adder_tree*18-1:0]  bias_all,
  input  logic [N_adder_tree*18-1:0]             psum,
  input  logic                                   psum_valid,
  output logic                                   psum_ready,
  output logic [N_adder_tree*18-1:0]             out_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [GRP_W-1:0]                       out_group,
  output logic                                   busy,
  output logic                                   done,
  output state_t                                 state_dbg
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready are both 1;
  // a producer holding valid keeps its data stable until that edge.

  localparam int VEC_W  = N_adder_tree * OUT_W;
  localparam int BVEC_W = N_adder_tree * BIAS_W;

  state_t                   state;
  logic [PASS_W-1:0]        pass_cnt;
  logic [GRP_W-1:0]         grp;
  logic signed [ACC_W-1:0]  acc      [N_adder_tree];
  logic signed [ACC_W-1:0]  acc_next [N_adder_tree];
  logic [VEC_W-1:0]         res_vec;
  logic [BVEC_W-1:0]        bias_sel;
  logic                     accept;
  logic                     pass_last;
  logic                     grp_last;

  assign accept    = psum_valid && psum_ready;
  assign pass_last = (pass_cnt == PASS_W'(NUM_PASSES - 1));
  assign grp_last  = (grp == GRP_W'(NUM_GROUPS - 1));
  assign state_dbg = state;

  always_comb begin
    bias_sel = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (grp == GRP_W'(g))
        bias_sel = bias_all[g*BVEC_W +: BVEC_W];
    end
  end

  generate
    for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
      bias_lane_sat #(
        .ACC_W   (ACC_W),
        .RELU_EN (RELU_EN)
      ) u_lane (
        .acc      (acc[i]),
        .psum     (psum[i*PSUM_W +: PSUM_W]),
        .bias     (bias_sel[i*BIAS_W +: BIAS_W]),
        .acc_next (acc_next[i]),
        .result   (res_vec[i*OUT_W +: OUT_W])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pass_cnt   <= '0;
      grp        <= '0;
      psum_ready <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      out_data   <= '0;
      out_group  <= '0;
      for (int i = 0; i < N_adder_tree; i++) acc[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= ACCUM;
            pass_cnt   <= '0;
            grp        <= '0;
            psum_ready <= 1'b1;
            busy       <= 1'b1;
            for (int i = 0; i < N_adder_tree; i++) acc[i] <= '0;
          end
        end
        ACCUM: begin
          if (accept) begin
            // Last pass bypasses the accumulator: the lane adders already include this psum.
            if (pass_last) begin
              out_data   <= res_vec;
              out_group  <= grp;
              out_valid  <= 1'b1;
              psum_ready <= 1'b0;
              state      <= EMIT;
            end else begin
              pass_cnt <= pass_cnt + 1'b1;
              for (int i = 0; i < N_adder_tree; i++) acc[i] <= acc_next[i];
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            pass_cnt  <= '0;
            for (int i = 0; i < N_adder_tree; i++) acc[i] <= '0;
            if (grp_last) begin
              grp   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              grp        <= grp + 1'b1;
              psum_ready <= 1'b1;
              state      <= ACCUM;
            end
          end
        end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
